// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage issue/execute stage in front of a 32-bit yAlu.
//
// Accepts decoded RISC-V R-type (OP) and I-type (OP-IMM) ALU instructions on
// a valid/ready handshake. Translates opcode/funct3/funct7 into the 3-bit
// yAlu op code and registers operands into S1. The yAlu datapath evaluates
// combinationally on S1, and its result is registered into S2 for the
// downstream valid/ready handshake. Unsupported encodings are flagged, flow
// through the pipe and return result 0. Completed output transfers are
// counted in `retired`.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake
//   in_opcode         instruction[6:0]
//   in_funct3         instruction[14:12]
//   in_funct7         instruction[31:25]
//   in_rs1, in_rs2    register operand values
//   in_imm            instruction[31:20], raw (sign-extended here)
//   out_valid/ready   downstream handshake
//   out_result        ALU result (0 for illegal instructions)
//   out_zero          result equals zero
//   out_illegal       instruction was not a supported ALU op
//   retired           wrapping count of completed output transfers
module alu_issue_stage #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [W-1:0]     in_rs1,
  input  logic [W-1:0]     in_rs2,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OpcR     = 7'b0110011;
  localparam logic [6:0] OpcI     = 7'b0010011;
  localparam logic [6:0] Funct7Z  = 7'b0000000;
  localparam logic [6:0] Funct7Alt = 7'b0100000;

  // yAlu op codes: bit 2 inverts b and injects carry-in, bits [1:0] select.
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;

  // ---------------------------------------------------------------------------
  // Decode (input cycle)
  // ---------------------------------------------------------------------------
  logic         dec_is_r;
  logic         dec_is_i;
  logic         dec_illegal;
  logic [2:0]   dec_op;
  logic [W-1:0] dec_b;

  always_comb begin
    dec_is_r    = (in_opcode == OpcR);
    dec_is_i    = (in_opcode == OpcI);
    dec_op      = AluAnd;
    dec_illegal = 1'b0;

    unique case (in_funct3)
      3'b000: dec_op = (dec_is_r && (in_funct7 == Funct7Alt)) ? AluSub : AluAdd;
      3'b110: dec_op = AluOr;
      3'b111: dec_op = AluAnd;
      default: dec_illegal = 1'b1;
    endcase

    if (!dec_is_r && !dec_is_i) begin
      dec_illegal = 1'b1;
    end
    // Only R-type constrains funct7; for OP-IMM those bits are immediate.
    if (dec_is_r && (in_funct7 != Funct7Z) && (in_funct7 != Funct7Alt)) begin
      dec_illegal = 1'b1;
    end
    if (dec_illegal) begin
      dec_op = AluAnd;
    end

    dec_b = dec_is_r ? in_rs2 : {{(W-12){in_imm[11]}}, in_imm};
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic s1_moves;
  logic s1_load;
  logic accept;
  logic out_xfer;

  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_moves = s1_valid && s2_load;
    s1_load  = !s1_valid || s1_moves;
    // Held low while reset is asserted so the handshake reads 0 during reset.
    in_ready = s1_load && !reset;
    accept   = in_valid && in_ready;
    out_xfer = s2_valid && out_ready;
  end

  // ---------------------------------------------------------------------------
  // Stage S1: operands, op code, illegal flag
  // ---------------------------------------------------------------------------
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [2:0]   s1_op;
  logic         s1_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_illegal <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a       <= in_rs1;
        s1_b       <= dec_b;
        s1_op      <= dec_op;
        s1_illegal <= dec_illegal;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // yAlu datapath, combinational on S1
  // ---------------------------------------------------------------------------
  logic [W-1:0] alu_bb;
  logic [W-1:0] alu_sum;
  logic [W-1:0] alu_z;
  logic         alu_ex;

  always_comb begin
    alu_bb  = s1_op[2] ? ~s1_b : s1_b;
    // Carry-out of the adder is intentionally dropped (modulo 2^W).
    alu_sum = s1_a + alu_bb + {{(W-1){1'b0}}, s1_op[2]};
    unique case (s1_op[1:0])
      2'b00:   alu_z = s1_a & alu_bb;
      2'b01:   alu_z = s1_a | alu_bb;
      2'b10:   alu_z = alu_sum;
      default: alu_z = {{(W-1){1'b0}}, alu_sum[W-1]};  // slt
    endcase
    alu_ex = (alu_z == '0);
  end

  // ---------------------------------------------------------------------------
  // Stage S2: result, zero, illegal; retired counter
  // ---------------------------------------------------------------------------
  logic [W-1:0]     s2_result;
  logic             s2_zero;
  logic             s2_illegal;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      // Data only changes when a new entry arrives, keeping an idle output quiet.
      if (s1_valid) begin
        s2_result  <= s1_illegal ? '0 : alu_z;
        s2_zero    <= s1_illegal ? 1'b1 : alu_ex;
        s2_illegal <= s1_illegal;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_zero    = s2_zero;
  assign out_illegal = s2_illegal;
  assign retired     = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// backpressure / reset / counter-wrap sequences, and a randomized run against
// a behavioural reference model with a FIFO scoreboard.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [15:0] retired;

  // Narrow-counter instance sharing all inputs
  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_result4;
  logic        out_zero4;
  logic        out_illegal4;
  logic [3:0]  retired4;

  alu_issue_stage #(.W(32), .CNT_W(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_illegal(out_illegal),
    .retired    (retired)
  );

  alu_issue_stage #(.W(32), .CNT_W(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready4),
    .in_opcode  (in_opcode),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .out_result (out_result4),
    .out_zero   (out_zero4),
    .out_illegal(out_illegal4),
    .retired    (retired4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [11:0] imm;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          stamp;
  } exp_t;

  int   checks;
  int   failures;
  int   cyc;
  int   model_cnt;
  exp_t exp_q[$];
  exp_t drv_exp;
  logic prev_hold;
  logic [31:0] prev_res;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model straight from the instruction semantics.
  function automatic exp_t ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] a,
                                     input logic [31:0] rs2, input logic [11:0] imm);
    exp_t        e;
    logic [31:0] b;
    logic        is_r;
    logic        legal;
    is_r  = (opc == 7'h33);
    b     = is_r ? rs2 : 32'($signed(imm));
    legal = (is_r || opc == 7'h13) && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7) &&
            (!is_r || f7 == 7'h00 || f7 == 7'h20);
    e.stamp = 0;
    if (!legal) begin
      e.res = 32'd0;
      e.ill = 1'b1;
    end else begin
      e.ill = 1'b0;
      if (f3 == 3'd6)                       e.res = a | b;
      else if (f3 == 3'd7)                  e.res = a & b;
      else if (is_r && f7 == 7'h20)         e.res = a - b;
      else                                  e.res = a + b;
    end
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // One clock: check handshake/state expectations, score transfers, advance.
  task automatic cycle();
    logic exp_ir;
    logic exp_ov;
    logic xfer;
    logic acc;
    exp_t e;
    @(negedge clk);
    exp_ir = !reset && (exp_q.size() < 2 || out_ready);
    exp_ov = !reset && exp_q.size() > 0 && exp_q[0].stamp < cyc;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("retired", 32'(retired), 32'(model_cnt % 65536));
    chk("retired4", 32'(retired4), 32'(model_cnt % 16));
    if (prev_hold && exp_ov) chk("result_stable", out_result, prev_res);
    xfer = exp_ov && out_ready;
    acc  = in_valid && exp_ir;
    if (xfer) begin
      e = exp_q.pop_front();
      chk("out_result", out_result, e.res);
      chk("out_zero", 32'(out_zero), 32'(e.zero));
      chk("out_illegal", 32'(out_illegal), 32'(e.ill));
    end
    prev_hold = exp_ov && !out_ready;
    prev_res  = out_result;
    @(posedge clk);
    cyc++;
    if (xfer) model_cnt++;
    if (acc) begin
      e = drv_exp;
      e.stamp = cyc;
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.opcode;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
    drv_exp.res  = v.res;
    drv_exp.zero = v.zero;
    drv_exp.ill  = v.ill;
  endtask

  task automatic drive_rand();
    vec_t v;
    exp_t e;
    int   k;
    k = int'($urandom_range(0, 9));
    v.opcode = (k < 5) ? 7'h33 : (k < 9) ? 7'h13 : 7'($urandom);
    k = int'($urandom_range(0, 9));
    v.f3 = (k < 8) ? 3'($urandom_range(6, 8)) : 3'($urandom);  // 8 wraps to 000
    k = int'($urandom_range(0, 9));
    v.f7 = (k < 4) ? 7'h00 : (k < 8) ? 7'h20 : 7'($urandom);
    v.rs1 = $urandom;
    v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
    v.imm = 12'($urandom);
    e = ref_model(v.opcode, v.f3, v.f7, v.rs1, v.rs2, v.imm);
    v.res  = e.res;
    v.zero = e.zero;
    v.ill  = e.ill;
    drive_vec(v);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    prev_hold = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; model_cnt = 0; prev_hold = 1'b0; prev_res = '0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    drv_exp = '{res: 32'd0, zero: 1'b0, ill: 1'b0, stamp: 0};

    tbl[0] = '{7'h33, 3'd0, 7'h00, 32'h0000_0005, 32'h0000_0003, 12'h000, 32'h0000_0008, 1'b0, 1'b0};
    tbl[1] = '{7'h33, 3'd0, 7'h20, 32'h0000_0003, 32'h0000_0003, 12'h000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{7'h33, 3'd6, 7'h00, 32'hF0F0_0000, 32'h0F0F_FFFF, 12'h000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[3] = '{7'h33, 3'd7, 7'h00, 32'hFFFF_0000, 32'h00FF_FF00, 12'h000, 32'h00FF_0000, 1'b0, 1'b0};
    tbl[4] = '{7'h13, 3'd0, 7'h7F, 32'h0000_0010, 32'hDEAD_BEEF, 12'hFFF, 32'h0000_000F, 1'b0, 1'b0};
    tbl[5] = '{7'h13, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h1234_5678, 12'h001, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{7'h03, 3'd0, 7'h00, 32'h0000_0005, 32'h0000_0003, 12'h004, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7] = '{7'h33, 3'd1, 7'h00, 32'h0000_0005, 32'h0000_0003, 12'h000, 32'h0000_0000, 1'b1, 1'b1};
    tbl[8] = '{7'h33, 3'd0, 7'h01, 32'h0000_0005, 32'h0000_0003, 12'h000, 32'h0000_0000, 1'b1, 1'b1};

    // Reset state, sampled while reset is held
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    do_reset();

    // Four back-to-back R-type ops
    for (int i = 0; i < 4; i++) begin
      drive_vec(tbl[i]);
      cycle();
    end
    drain();
    chk("retired_after4", 32'(retired), 32'd4);

    // addi and illegal vectors
    for (int i = 4; i < 9; i++) begin
      drive_vec(tbl[i]);
      cycle();
    end
    drain();
    chk("retired_after9", 32'(retired), 32'd9);

    // Backpressure: three sends with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_vec(tbl[i]);
      cycle();
    end
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;  // third still offered
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_held", 32'(exp_q.size()), 32'd2);
    out_ready = 1'b1;
    #0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    cycle();  // transfer + accept of third on same edge
    in_valid = 1'b0;
    drain();
    chk("retired_after_bp", 32'(retired), 32'd12);

    // Reset mid-stream with two instructions in flight
    out_ready = 1'b0;
    drive_vec(tbl[2]); cycle();
    drive_vec(tbl[3]); cycle();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    chk("mid_rst_out_result", out_result, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    prev_hold = 1'b0;
    cycle();
    reset = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    drive_vec(tbl[0]); cycle();
    in_valid = 1'b0;
    drain();

    // Counter wrap on the CNT_W=4 instance: 17 transfers -> 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_vec(tbl[i % 9]);
      cycle();
    end
    drain();
    chk("wrap_retired4", 32'(retired4), 32'd1);
    chk("wrap_retired", 32'(retired), 32'd17);

    // Randomized regression against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) drive_rand();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-stage pipelined issue/execute stage that sits directly upstream of the 32-bit `yAlu`. It accepts decoded RISC-V R-type and I-type ALU instructions over a valid/ready handshake and translates opcode/funct3/funct7 into the 3-bit `yAlu` op code. It selects and registers operands, drives an internal `yAlu` instance, and presents the registered result downstream with its own valid/ready handshake. It also flags unsupported operations and counts retired results.

## Interface
- `W`, 32: datapath width; must equal the `yAlu` width.
- `CNT_W`, 16: width of the retired-result counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_opcode`  in  7  instruction[6:0].
- `in_funct3`  in  3  instruction[14:12].
- `in_funct7`  in  7  instruction[31:25].
- `in_rs1`  in  W  rs1 register value.
- `in_rs2`  in  W  rs2 register value.
- `in_imm`  in  12  instruction[31:20], raw.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream consumes the result.
- `out_result`  out  W  ALU result; 0 when illegal.
- `out_zero`  out  1  result equals 0; taken from `yAlu` ex.
- `out_illegal`  out  1  instruction was not a supported ALU op.
- `retired`  out  CNT_W  count of completed output transfers.

## Operation
- Decode happens in the input cycle and is registered into stage S1.
  - R-type: `in_opcode`=0110011, b = `in_rs2`. I-type: `in_opcode`=0010011, b = `in_imm` sign-extended to W.
  - a = `in_rs1` in both cases.
- Op mapping:
  - funct3 000 → op 010 (add).
  - funct3 000 with R-type and funct7=0100000 → op 110 (sub).
  - funct3 110 → op 001 (or).
  - funct3 111 → op 000 (and).
- Illegal: any other opcode, any other funct3, or R-type funct7 not in {0000000, 0100000}. An I-type with funct3 000 is addi and ignores funct7.
- An illegal instruction still flows through the pipe. S1 op is forced to 000 and the illegal bit is carried with it.
- S1 holds a, b, op, illegal and a valid bit. The `yAlu` instance is combinational on S1.
- S2 registers z, ex and illegal. When illegal, it stores result 0 and zero 1.
- Arithmetic is modulo 2^W. Carry/overflow out of add and sub is discarded.
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - `out_valid` stays high and the output data stays stable until a transfer.
  - `out_valid` is independent of `out_ready`.
- Advance rules:
  - S2 loads from S1 when `!s2_valid || out_ready`.
  - S1 loads when `!s1_valid || s1_moves`, where s1_moves = s1_valid && (S2 loads).
  - `in_ready` = `!s1_valid || s1_moves`, which is combinational from `out_ready` and the state.
- `retired` increments on each output transfer and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset value of every output and register is 0. This covers `in_ready` internal valids, `out_valid`, `out_result`, `out_zero`, `out_illegal` and `retired`.
- `in_ready` goes to 1 in the first cycle after reset deasserts, since both stages are empty.
- Latency: an instruction accepted at edge N produces `out_valid`=1 after edge N+1, so the result is consumable at edge N+2.
- Throughput is one instruction per cycle while `out_ready`=1.
- Backpressure:
  - With `out_ready`=0, at most 2 instructions are held (S1 and S2), then `in_ready`=0.
  - When `out_ready` rises, the output transfer and the S1→S2 move happen on the same edge, so `in_ready` is already 1 in that cycle.
- Simultaneous output transfer and input accept in the same cycle is legal and loses no data.
- Reset asserted mid-operation:
  - All valids clear immediately, asynchronously, and in-flight instructions are dropped.
  - `retired` returns to 0.
  - No `out_valid` appears until a new accept.
- The counter is not updated on a cycle where `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset then 4 back-to-back instructions with `out_ready`=1 → first `out_valid` exactly 2 cycles after the first accept, one result per cycle after that, then `retired`=4.
  - R add: rs1=0x0000_0005, rs2=0x0000_0003 → 0x0000_0008.
  - R sub: funct7=0100000, rs1=3, rs2=3 → result 0, `out_zero`=1.
  - or: 0xF0F0_0000 | 0x0F0F_FFFF → 0xFFFF_FFFF.
  - and: 0xFFFF_0000 & 0x00FF_FF00 → 0x00FF_0000.
- I-type addi: rs1=0x0000_0010, imm=0xFFF → 0x0000_000F. Wrap case: rs1=0xFFFF_FFFF, imm=0x001 → 0x0000_0000, `out_zero`=1.
- Illegal cases → `out_illegal`=1, result 0, `out_zero`=1, and each still counts in `retired`.
  - opcode 0000011.
  - R-type funct3 001.
  - R-type funct7=0000001.
- Backpressure: hold `out_ready`=0 while sending 3 instructions.
  - → `in_ready` drops after the 2nd accept, and `out_result` stays stable.
  - Release `out_ready` → all 3 results arrive in order, with no duplicate and no loss.
- Assert `reset` mid-stream with 2 instructions in flight.
  - → `out_valid`, `retired` and `out_result` go to 0 immediately, without waiting for a clock edge.
  - After reset releases, the next accepted instruction appears 2 cycles later.
- Counter wrap, with a `CNT_W`=4 instance: 17 transfers → `retired`=1.
- Randomized regression: random rs1/rs2/imm/op compared against an a&b / a|b / a+b / a−b reference model.
